ysyx_23060184_ifu: RTL
======================

# ysyx_23060184_ifu

Instruction fetch unit for the NPC core. Holds the architectural PC, issues one instruction-memory read per instruction over a valid/ready request/response interface, and hands the fetched instruction downstream to decode. It sits directly upstream of the PC-source mux: it supplies `pc_o` and `pc_plus4_o` to that mux, and loads the mux output (NPC) back into the PC when the executing instruction retires.

## Interface
- `DATA_WIDTH`, 32: PC, address and instruction width.
- `RESET_PC`, 32'h8000_0000: PC value after reset.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `npc_i` in DATA_WIDTH: next PC from the PC-source mux.
- `npc_valid_i` in 1: single-cycle pulse; current instruction retired, `npc_i` valid.
- `imem_req_valid_o` out 1: fetch request valid.
- `imem_req_ready_i` in 1: memory accepts request.
- `imem_addr_o` out DATA_WIDTH: fetch address; equals current PC.
- `imem_resp_valid_i` in 1: read data valid; single-cycle pulse.
- `imem_rdata_i` in DATA_WIDTH: fetched instruction.
- `inst_valid_o` out 1: instruction available to decode.
- `inst_ready_i` in 1: decode accepts instruction.
- `inst_o` out DATA_WIDTH: registered instruction.
- `pc_o` out DATA_WIDTH: PC of the instruction in flight.
- `pc_plus4_o` out DATA_WIDTH: `pc_o + 4`, mod 2^DATA_WIDTH; feeds the mux PCPlus4 input.
- `fetch_err_o` out 1: misaligned-NPC trap flag. Only meaningful with the `_EN` macro defined.

## Operation
- FSM states: BOOT, FETCH, WAIT, DELIVER, EXEC, TRAP. TRAP exists only with the macro defined.
- **BOOT**: entered on reset. Always moves to FETCH on the next cycle.
- **FETCH**: `imem_req_valid_o=1`, `imem_addr_o=pc`.
  - If `imem_req_ready_i=1`, go to WAIT.
  - Request valid and address are held stable until accepted.
- **WAIT**: request outputs are low.
  - On `imem_resp_valid_i=1`, latch `imem_rdata_i` into `inst_o` and go to DELIVER.
- **DELIVER**: `inst_valid_o=1`.
  - `inst_o` and `pc_o` are held stable until `inst_ready_i=1`, then go to EXEC.
- **EXEC**: waits for retirement.
  - On `npc_valid_i=1`, load `pc <= npc_i` and go to FETCH.
- Events outside their state are ignored with no state change:
  - `npc_valid_i` outside EXEC.
  - `imem_resp_valid_i` outside WAIT.
- Exactly one request is outstanding at a time. No prefetch and no speculation.
- `pc_plus4_o` is combinational from the PC register; carry out is discarded (0xFFFF_FFFC+4 → 0).

## Timing
- Reset: `pc=RESET_PC`, `inst_o=0`, state=BOOT. While in BOOT and during reset:
  - `imem_req_valid_o=0`, `inst_valid_o=0`, `fetch_err_o=0`.
  - `imem_addr_o=pc_o=RESET_PC`, `pc_plus4_o=RESET_PC+4`.
- First request: `imem_req_valid_o=1` in the second cycle after `rst` deasserts.
- Latency with zero-wait memory and decode:
  - Request accepted at cycle N.
  - Response no earlier than N+1.
  - `inst_valid_o` asserted the cycle after the response.
  - Decode handshake at that edge moves to EXEC.
  - `npc_valid_i` at cycle K makes a new request visible at K+1.
- Minimum of 4 cycles per instruction, plus memory and execute latency.
- `rst` asserted in any state, including mid-request: return to BOOT next edge and drop any pending response. The memory must tolerate an abandoned request.

## Configuration
- `YSYX_23060184_IFU_ALIGN_CHECK_EN` defined:
  - In EXEC, `npc_valid_i=1` with `npc_i[1:0]!=0` loads `pc<=npc_i` and enters TRAP.
  - TRAP sets `fetch_err_o=1`, which stays asserted until reset.
  - No further requests or instructions are issued; TRAP exits only on `rst`.
- Not defined:
  - No alignment check; `npc_i` is loaded and issued unchanged.
  - `fetch_err_o` is tied 0; TRAP is not implemented.

## Test plan
- Reset release, memory always ready, 1-cycle response of 0x0000_0013, decode always ready:
  - `imem_addr_o=0x8000_0000`, `inst_o=0x13`.
  - `npc_valid_i` with `npc_i=0x8000_0004` produces a next request at 0x8000_0004.
- `imem_req_ready_i` low for 3 cycles: `imem_req_valid_o` and address are held; no WAIT entry until ready.
- `inst_ready_i` low for 5 cycles in DELIVER: `inst_o` and `pc_o` stay stable and `inst_valid_o` stays high. A `npc_valid_i` pulse in this window is ignored.
- Jump in EXEC with `npc_i=0x8000_0100`:
  - `pc_o=0x8000_0100`, `pc_plus4_o=0x8000_0104`.
  - Wrap check: with `npc_i=0xFFFF_FFFC`, `pc_plus4_o=0`.
- `rst` pulsed in WAIT, followed by a stale `imem_resp_valid_i`: state is BOOT and the stale response is ignored. The first request after reset is to 0x8000_0000.
- Macro defined, `npc_i=0x8000_0002`: `fetch_err_o=1` next cycle and no further requests. Macro undefined: request to 0x8000_0002 and `fetch_err_o=0`.

Source files
------------

// File: rtl/ysyx_23060184_ifu.sv
// Instruction fetch unit: holds the PC, issues one imem read per instruction, hands it to decode.
// Optional misaligned-NPC trap is built when YSYX_23060184_IFU_ALIGN_CHECK_EN is defined.
module ysyx_23060184_ifu #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] npc_i,
  input  logic                  npc_valid_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  fetch_err_o,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    EXEC    = 3'd4
`ifdef YSYX_23060184_IFU_ALIGN_CHECK_EN
    , TRAP  = 3'd5
`endif
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] inst;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload stay stable until that edge, and a response pulse is only
  // consumed in WAIT, so one request is outstanding at most.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
      inst  <= '0;
    end else begin
      case (state)
        BOOT:    state <= FETCH;
        FETCH:   if (imem_req_ready_i) state <= WAIT;
        WAIT: begin
          if (imem_resp_valid_i) begin
            inst  <= imem_rdata_i;
            state <= DELIVER;
          end
        end
        DELIVER: if (inst_ready_i) state <= EXEC;
        EXEC: begin
          if (npc_valid_i) begin
            pc <= npc_i;
`ifdef YSYX_23060184_IFU_ALIGN_CHECK_EN
            state <= (npc_i[1:0] != 2'b00) ? TRAP : FETCH;
`else
            state <= FETCH;
`endif
          end
        end
`ifdef YSYX_23060184_IFU_ALIGN_CHECK_EN
        TRAP:    state <= TRAP;
`endif
        default: state <= BOOT;
      endcase
    end
  end

  assign imem_req_valid_o = (state == FETCH);
  assign inst_valid_o     = (state == DELIVER);
  assign imem_addr_o      = pc;
  assign pc_o             = pc;
  assign inst_o           = inst;
  assign pc_plus4_o       = pc + DATA_WIDTH'(4);
  assign dbg_state_o      = state;

`ifdef YSYX_23060184_IFU_ALIGN_CHECK_EN
  assign fetch_err_o = (state == TRAP);
`else
  assign fetch_err_o = 1'b0;
`endif

endmodule
